// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// access-size codes, STATUS bit positions and the serialiser state type.
package uart_tx_mmio_pkg;

    // Register select is addr[4:3]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_BUSY      = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // A programmed divisor of zero behaves as one clock per bit
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == '0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus slice seen by the UART: decoded select, offset, direction,
// access size, write data and combinational read data.
interface uart_tx_mmio_if;
    logic        sel;
    logic [4:0]  addr;
    logic        rw;
    logic [1:0]  word;
    logic [63:0] wdata;
    logic [63:0] rdata;

    modport master (
        output sel, addr, rw, word, wdata,
        input  rdata
    );

    modport slave (
        input  sel, addr, rw, word, wdata,
        output rdata
    );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with unregistered head output; the caller guarantees push
// only when not full (or when popping) and pop only when not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/DIV registers,
// bit timer and serialiser FSM draining a TX FIFO onto txd.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          txd,
    output logic          irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          wr_en;
    logic          push_req;
    logic          status_wr;
    logic          div_wr;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [15:0]   bit_load;

    tx_state_e     state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q,   txd_d;
    logic          ovf_q,   ovf_d;
    logic [15:0]   div_q,   div_d;

    logic          unused_bus;
    assign unused_bus = ^{bus.wdata[63:16], bus.addr[2:0]};

    assign reg_sel   = bus.addr[4:3];
    assign wr_en     = bus.sel && bus.rw;
    assign push_req  = wr_en && (reg_sel == REG_TXDATA);
    assign status_wr = wr_en && (reg_sel == REG_STATUS);
    assign div_wr    = wr_en && (reg_sel == REG_DIV);

    // A full FIFO still accepts a byte when the serialiser frees a slot this cycle
    assign fifo_pop  = (state_q == TX_IDLE) && !fifo_empty;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign overflow  = push_req && !fifo_push;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (status_wr) ovf_d = 1'b0;
        if (overflow)  ovf_d = 1'b1;

        div_d = div_q;
        if (div_wr) begin
            if (bus.word == SZ_B) div_d = {div_q[15:8], bus.wdata[7:0]};
            else                  div_d = bus.wdata[15:0];
        end
    end

    // Reloaded only on bit boundaries, so a DIV write never stretches the current bit
    assign bit_load = eff_div(div_q) - 16'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    shift_d = fifo_rdata;
                    timer_d = bit_load;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (timer_q == '0) begin
                    timer_d = bit_load;
                    idx_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (timer_q == '0) begin
                    timer_d = bit_load;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = TX_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (timer_q == '0) state_d = TX_IDLE;
                else               timer_d = timer_q - 16'd1;
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level registered from next state so txd lines up with state_q
        unique case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            div_q   <= 16'(DEFAULT_DIV);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
        end
    end

    assign txd = txd_q;
    assign irq = fifo_empty && (state_q == TX_IDLE);

    always_comb begin
        bus.rdata = '0;
        if (bus.sel && !bus.rw) begin
            unique case (reg_sel)
                REG_STATUS: begin
                    bus.rdata[ST_FULL]                = fifo_full;
                    bus.rdata[ST_EMPTY]               = fifo_empty;
                    bus.rdata[ST_BUSY]                = (state_q != TX_IDLE);
                    bus.rdata[ST_OVF]                 = ovf_q;
                    bus.rdata[ST_COUNT_LSB +: 8]      = 8'(fifo_count);
                end
                REG_DIV:  bus.rdata[15:0] = div_q;
                default:  bus.rdata = '0;
            endcase
        end
    end

endmodule
